// File: rtl/axi_burst_mst_ctrl.sv
// AXI4 burst master controller: one fixed-length INCR write or read
// burst per command, with per-handshake timeout and sticky status flags.
module axi_burst_mst_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_BURST_LEN        = 4,
    parameter int C_TIMEOUT          = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic [1:0]                    op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr,
    input  logic [32*C_BURST_LEN-1:0]     wr_data,
    output logic [32*C_BURST_LEN-1:0]     rd_data,
    output logic                          busy,
    output logic                          wr_done,
    output logic                          rd_done,
    output logic                          err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [31:0]                   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [31:0]                   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int BW = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
    localparam int TW = $clog2(C_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST = BW'(C_BURST_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(C_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]                    state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [32*C_BURST_LEN-1:0]     wbuf;
    logic [BW-1:0]                 beat;
    logic [TW-1:0]                 wait_cnt;
    logic                          hs;
    logic                          waiting;
    logic                          tmo;
    logic                          last_cnt;

    // Handshake completing this cycle in whichever state is waiting on the bus
    always_comb begin
        hs      = 1'b0;
        waiting = 1'b1;
        case (state)
            S_AW:    hs = m_axi_awready;
            S_W:     hs = m_axi_wready;
            S_B:     hs = m_axi_bvalid;
            S_AR:    hs = m_axi_arready;
            S_R:     hs = m_axi_rvalid;
            default: waiting = 1'b0;
        endcase
    end

    assign tmo      = waiting && !hs && (wait_cnt == TMAX);
    assign last_cnt = (beat == LAST);

    // Main FSM, beat counter, wait counter, capture registers and flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wbuf     <= '0;
            beat     <= '0;
            wait_cnt <= '0;
            rd_data  <= '0;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (!waiting || hs)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;

            if (tmo) begin
                err   <= 1'b1;
                beat  <= '0;
                state <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        wr_done <= 1'b0;
                        rd_done <= 1'b0;
                        err     <= 1'b0;
                        beat    <= '0;
                        if (op == 2'b01) begin
                            addr_q <= wr_addr;
                            wbuf   <= wr_data;
                            state  <= S_AW;
                        end else if (op == 2'b10) begin
                            addr_q <= rd_addr;
                            state  <= S_AR;
                        end else begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_AW: if (hs) state <= S_W;
                    S_W: if (hs) begin
                        if (last_cnt) begin
                            beat  <= '0;
                            state <= S_B;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    S_B: if (hs) begin
                        wr_done <= 1'b1;
                        if (m_axi_bresp != 2'b00) err <= 1'b1;
                        state <= S_DONE;
                    end
                    S_AR: if (hs) state <= S_R;
                    S_R: if (hs) begin
                        rd_data[{beat, 5'b0} +: 32] <= m_axi_rdata;
                        if (m_axi_rresp != 2'b00) err <= 1'b1;
                        if (m_axi_rlast != last_cnt) err <= 1'b1;
                        if (m_axi_rlast || last_cnt) begin
                            rd_done <= 1'b1;
                            beat    <= '0;
                            state   <= S_DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy          = (state != S_IDLE);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(C_BURST_LEN - 1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state == S_AW);

    assign m_axi_wdata   = wbuf[{beat, 5'b0} +: 32];
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = (state == S_W) && last_cnt;
    assign m_axi_wvalid  = (state == S_W);

    assign m_axi_bready  = (state == S_B);

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(C_BURST_LEN - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state == S_AR);

    assign m_axi_rready  = (state == S_R);

endmodule

// File: tb/tb_axi_burst_mst_ctrl.sv
// Directed testbench for axi_burst_mst_ctrl: scripted AXI slave driven
// from tasks at the falling edge, with hand-computed expectations.
module tb_axi_burst_mst_ctrl;

    localparam int AW = 32;
    localparam int BL = 4;
    localparam int TO = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [127:0]  wr_data = '0;
    logic [127:0]  rd_data;
    logic          busy, wr_done, rd_done, err;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_wlast;
    logic          m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_awready = 1'b0;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_arready = 1'b0;
    logic [31:0]   m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] rwords [4];
    int          aw_cnt, ar_cnt, wn, awv_seen, arv_seen, wv_seen;
    int          first_wr, first_rd, first_err, first_idle;
    int          viol, attr_bad;
    bit          timed_out;
    logic [31:0] obs_awaddr, obs_araddr;
    logic [7:0]  obs_awlen, obs_arlen;
    logic [31:0] obs_w [4];
    logic [3:0]  obs_wlast;

    localparam logic [127:0] WORDS =
        {32'hFEDCBA98, 32'h76543210, 32'h89ABCDEF, 32'h01234567};

    axi_burst_mst_ctrl #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_BURST_LEN(BL),
        .C_TIMEOUT(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .op(op),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .wr_done(wr_done),
        .rd_done(rd_done), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    task automatic start_cmd(input logic [1:0] o, input logic [31:0] wa,
                             input logic [31:0] ra, input logic [127:0] wd);
        @(negedge aclk);
        op      = o;
        wr_addr = wa;
        rd_addr = ra;
        wr_data = wd;
        start   = 1'b1;
    endtask

    // Slave model; cycle index 1 is the first falling edge after start.
    task automatic slave_run(input int aw_delay, input bit w_tog,
                             input logic [1:0] bresp_v, input bit ar_hold,
                             input int rlast_at, input logic [1:0] rresp_v,
                             input int mid_cyc);
        int aw_wait;
        int rb;
        bit tog, b_arm, r_act, pawst, pwst;
        logic [31:0] pad, pwd;
        aw_wait = 0; rb = 0; tog = 0; b_arm = 0; r_act = 0;
        pawst = 0; pwst = 0; pad = '0; pwd = '0;
        aw_cnt = 0; ar_cnt = 0; wn = 0; awv_seen = 0; arv_seen = 0;
        wv_seen = 0; first_wr = 0; first_rd = 0; first_err = 0;
        first_idle = 0; viol = 0; attr_bad = 0; timed_out = 0;
        obs_wlast = '0;
        for (int k = 0; k < 4; k++) obs_w[k] = '0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge aclk);
            start = (cyc == mid_cyc);
            if (cyc == mid_cyc) op = 2'b10;
            if (pawst && (!m_axi_awvalid || m_axi_awaddr !== pad)) viol++;
            if (pwst && (!m_axi_wvalid || m_axi_wdata !== pwd)) viol++;
            if (m_axi_awvalid) awv_seen++;
            if (m_axi_arvalid) arv_seen++;
            if (m_axi_wvalid) wv_seen++;
            if (m_axi_awvalid && aw_wait < aw_delay) begin
                m_axi_awready = 1'b0;
                aw_wait++;
            end else begin
                m_axi_awready = m_axi_awvalid;
            end
            tog = !tog;
            m_axi_wready  = w_tog ? tog : 1'b1;
            m_axi_arready = !ar_hold;
            m_axi_bvalid  = b_arm;
            m_axi_bresp   = b_arm ? bresp_v : 2'b00;
            m_axi_rvalid  = r_act;
            m_axi_rdata   = (rb < 4) ? rwords[rb] : 32'h0;
            m_axi_rlast   = r_act && (rb == rlast_at);
            m_axi_rresp   = r_act ? rresp_v : 2'b00;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                obs_awaddr = m_axi_awaddr;
                obs_awlen  = m_axi_awlen;
                if (m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01)
                    attr_bad++;
            end
            if (m_axi_bvalid && m_axi_bready) b_arm = 0;
            if (m_axi_wvalid && m_axi_wready) begin
                if (wn < 4) begin
                    obs_w[wn]     = m_axi_wdata;
                    obs_wlast[wn] = m_axi_wlast;
                end
                if (m_axi_wstrb !== 4'hF) attr_bad++;
                if (m_axi_wlast) b_arm = 1;
                wn++;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt++;
                obs_araddr = m_axi_araddr;
                obs_arlen  = m_axi_arlen;
                if (m_axi_arsize !== 3'b010 || m_axi_arburst !== 2'b01)
                    attr_bad++;
                r_act = 1;
                rb    = 0;
            end else if (m_axi_rvalid && m_axi_rready) begin
                if (m_axi_rlast) r_act = 0;
                rb++;
                if (rb >= 4) r_act = 0;
            end
            pawst = m_axi_awvalid && !m_axi_awready;
            pad   = m_axi_awaddr;
            pwst  = m_axi_wvalid && !m_axi_wready;
            pwd   = m_axi_wdata;
            if (wr_done && first_wr == 0) first_wr = cyc;
            if (rd_done && first_rd == 0) first_rd = cyc;
            if (err && first_err == 0) first_err = cyc;
            if (!busy && cyc >= 2) begin
                first_idle = cyc;
                break;
            end
        end
        if (first_idle == 0) timed_out = 1;
        start = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        m_axi_bresp = 2'b00; m_axi_rresp = 2'b00;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge aclk);
        checks++;
        if ({busy, wr_done, rd_done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {busy, wr_done, rd_done, err});
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
             m_axi_arvalid, m_axi_rready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_axi got %b want 000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
                      m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        checks++;
        if (rd_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 0", rd_data);
        end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_write;
        start_cmd(2'b01, 32'hC000_0000, 32'h0, WORDS);
        slave_run(0, 0, 2'b00, 0, 3, 2'b00, 0);
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL wr_budget got timeout want idle");
        end
        checks++;
        if (aw_cnt !== 1 || obs_awaddr !== 32'hC000_0000 || obs_awlen !== 8'd3) begin
            errors++;
            $display("FAIL wr_aw got cnt=%0d addr=%h len=%0d want 1 c0000000 3",
                     aw_cnt, obs_awaddr, obs_awlen);
        end
        checks++;
        if (wn !== 4 || {obs_w[3], obs_w[2], obs_w[1], obs_w[0]} !== WORDS) begin
            errors++;
            $display("FAIL wr_beats got n=%0d %h %h %h %h want 4 beats %h",
                     wn, obs_w[0], obs_w[1], obs_w[2], obs_w[3], WORDS);
        end
        checks++;
        if (obs_wlast !== 4'b1000 || attr_bad !== 0) begin
            errors++;
            $display("FAIL wr_wlast got %b attr=%0d want 1000 0",
                     obs_wlast, attr_bad);
        end
        checks++;
        if (first_wr !== 7 || first_idle !== 8) begin
            errors++;
            $display("FAIL wr_latency got done=%0d idle=%0d want 7 8",
                     first_wr, first_idle);
        end
        checks++;
        if (err !== 1'b0 || wr_done !== 1'b1 || ar_cnt !== 0) begin
            errors++;
            $display("FAIL wr_status got err=%b done=%b ar=%0d want 0 1 0",
                     err, wr_done, ar_cnt);
        end
    endtask

    task automatic test_read;
        rwords[0] = 32'h01234567; rwords[1] = 32'h89ABCDEF;
        rwords[2] = 32'h76543210; rwords[3] = 32'hFEDCBA98;
        start_cmd(2'b10, 32'h0, 32'hD000_0000, 128'h0);
        slave_run(0, 0, 2'b00, 0, 3, 2'b00, 0);
        checks++;
        if (ar_cnt !== 1 || obs_araddr !== 32'hD000_0000 || obs_arlen !== 8'd3) begin
            errors++;
            $display("FAIL rd_ar got cnt=%0d addr=%h len=%0d want 1 d0000000 3",
                     ar_cnt, obs_araddr, obs_arlen);
        end
        checks++;
        if (rd_data !== WORDS) begin
            errors++;
            $display("FAIL rd_data got %h want %h", rd_data, WORDS);
        end
        checks++;
        if (first_rd !== 6 || rd_done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rd_done got at=%0d done=%b err=%b want 6 1 0",
                     first_rd, rd_done, err);
        end
        checks++;
        if (wr_done !== 1'b0 || aw_cnt !== 0 || attr_bad !== 0) begin
            errors++;
            $display("FAIL rd_side got wr_done=%b aw=%0d attr=%0d want 0 0 0",
                     wr_done, aw_cnt, attr_bad);
        end
    endtask

    task automatic test_backpressure;
        start_cmd(2'b01, 32'hC000_1000, 32'h0, WORDS);
        slave_run(5, 1, 2'b00, 0, 3, 2'b00, 3);
        checks++;
        if (aw_cnt !== 1 || awv_seen !== 6 || obs_awaddr !== 32'hC000_1000) begin
            errors++;
            $display("FAIL bp_aw got cnt=%0d held=%0d addr=%h want 1 6 c0001000",
                     aw_cnt, awv_seen, obs_awaddr);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL bp_stable got %0d violations want 0", viol);
        end
        checks++;
        if (wn !== 4 || {obs_w[3], obs_w[2], obs_w[1], obs_w[0]} !== WORDS
            || obs_wlast !== 4'b1000) begin
            errors++;
            $display("FAIL bp_beats got n=%0d last=%b want 4 1000",
                     wn, obs_wlast);
        end
        checks++;
        if (wr_done !== 1'b1 || err !== 1'b0 || arv_seen !== 0) begin
            errors++;
            $display("FAIL bp_status got done=%b err=%b arv=%0d want 1 0 0",
                     wr_done, err, arv_seen);
        end
    endtask

    task automatic test_bresp_err;
        start_cmd(2'b01, 32'hC000_2000, 32'h0, WORDS);
        slave_run(0, 0, 2'b10, 0, 3, 2'b00, 0);
        checks++;
        if (wr_done !== 1'b1 || err !== 1'b1 || first_err !== 7) begin
            errors++;
            $display("FAIL bresp got done=%b err=%b at=%0d want 1 1 7",
                     wr_done, err, first_err);
        end
    endtask

    task automatic test_illegal_op;
        start_cmd(2'b11, 32'hC000_3000, 32'hD000_3000, WORDS);
        slave_run(0, 0, 2'b00, 0, 3, 2'b00, 0);
        checks++;
        if (err !== 1'b1 || first_err !== 1 || first_idle !== 2) begin
            errors++;
            $display("FAIL illegal_err got err=%b at=%0d idle=%0d want 1 1 2",
                     err, first_err, first_idle);
        end
        checks++;
        if (awv_seen !== 0 || arv_seen !== 0 || wv_seen !== 0 || wr_done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_axi got aw=%0d ar=%0d w=%0d wr_done=%b want 0 0 0 0",
                     awv_seen, arv_seen, wv_seen, wr_done);
        end
    endtask

    task automatic test_timeout;
        start_cmd(2'b10, 32'h0, 32'hD000_4000, 128'h0);
        slave_run(0, 0, 2'b00, 1, 3, 2'b00, 0);
        checks++;
        if (arv_seen !== 16 || first_err !== 17 || ar_cnt !== 0) begin
            errors++;
            $display("FAIL timeout got arv=%0d err_at=%0d ar=%0d want 16 17 0",
                     arv_seen, first_err, ar_cnt);
        end
        checks++;
        if (first_idle !== 18 || m_axi_arvalid !== 1'b0 || rd_done !== 1'b0
            || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end got idle=%0d arv=%b rd_done=%b err=%b want 18 0 0 1",
                     first_idle, m_axi_arvalid, rd_done, err);
        end
    endtask

    task automatic test_early_rlast;
        rwords[0] = 32'hAAAA0000; rwords[1] = 32'hAAAA0001;
        rwords[2] = 32'hAAAA0002; rwords[3] = 32'hAAAA0003;
        start_cmd(2'b10, 32'h0, 32'hD000_5000, 128'h0);
        slave_run(0, 0, 2'b00, 0, 1, 2'b00, 0);
        checks++;
        if (rd_data !== {32'hFEDCBA98, 32'h76543210, 32'hAAAA0001, 32'hAAAA0000}) begin
            errors++;
            $display("FAIL early_rlast_data got %h want fedcba9876543210aaaa0001aaaa0000",
                     rd_data);
        end
        checks++;
        if (rd_done !== 1'b1 || err !== 1'b1 || first_rd !== 4) begin
            errors++;
            $display("FAIL early_rlast got done=%b err=%b at=%0d want 1 1 4",
                     rd_done, err, first_rd);
        end
    endtask

    task automatic test_missing_rlast;
        rwords[0] = 32'h11111111; rwords[1] = 32'h22222222;
        rwords[2] = 32'h33333333; rwords[3] = 32'h44444444;
        start_cmd(2'b10, 32'h0, 32'hD000_6000, 128'h0);
        slave_run(0, 0, 2'b00, 0, 9, 2'b00, 0);
        checks++;
        if (rd_data !== {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}
            || rd_done !== 1'b1 || err !== 1'b1 || first_rd !== 6) begin
            errors++;
            $display("FAIL missing_rlast got data=%h done=%b err=%b at=%0d want 4 beats 1 1 6",
                     rd_data, rd_done, err, first_rd);
        end
    endtask

    task automatic test_reset_mid;
        start_cmd(2'b01, 32'hC000_7000, 32'h0, WORDS);
        @(negedge aclk);
        start = 0;
        m_axi_awready = 1;
        m_axi_wready  = 1;
        repeat (3) @(negedge aclk);
        checks++;
        if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== 32'h76543210) begin
            errors++;
            $display("FAIL mid_pre got wvalid=%b wdata=%h want 1 76543210",
                     m_axi_wvalid, m_axi_wdata);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({busy, wr_done, rd_done, err, m_axi_awvalid, m_axi_wvalid,
             m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 10'b0
            || rd_data !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset got %b rd=%h want all 0",
                     {busy, wr_done, rd_done, err, m_axi_awvalid, m_axi_wvalid,
                      m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready},
                     rd_data);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            checks++;
            if ({busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 4'b0) begin
                errors++;
                $display("FAIL mid_quiet got %b want 0000",
                         {busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid});
            end
        end
        m_axi_awready = 0;
        m_axi_wready  = 0;
        start_cmd(2'b01, 32'hC000_8000, 32'h0, WORDS);
        slave_run(0, 0, 2'b00, 0, 3, 2'b00, 0);
        checks++;
        if (wn !== 4 || {obs_w[3], obs_w[2], obs_w[1], obs_w[0]} !== WORDS
            || first_wr !== 7 || err !== 1'b0 || obs_awaddr !== 32'hC000_8000) begin
            errors++;
            $display("FAIL mid_after got n=%0d done_at=%0d err=%b addr=%h want 4 7 0 c0008000",
                     wn, first_wr, err, obs_awaddr);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_backpressure;
        test_bresp_err;
        test_illegal_op;
        test_timeout;
        test_early_rlast;
        test_missing_rlast;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
